// File: rtl/vivaldi_synth_if.sv
// vivaldi_synth_if: control and sample bus of the vivaldi oscillator
interface vivaldi_synth_if #(
   parameter int PHASE_W = 32
);
   logic               enable_i;
   logic [1:0]         wave_sel_i;
   logic [6:0]         gain_pct_i;
   logic [PHASE_W-1:0] phase_inc_i;
   logic [15:0]        sample_o;
   logic               sample_valid_o;
   modport master (
      output enable_i, wave_sel_i, gain_pct_i, phase_inc_i,
      input  sample_o, sample_valid_o
   );
   modport slave (
      input  enable_i, wave_sel_i, gain_pct_i, phase_inc_i,
      output sample_o, sample_valid_o
   );
endinterface

// File: rtl/vivaldi_synth.sv
// vivaldi_synth: phase-accumulator oscillator (sine/square/saw/triangle) with percent gain
module vivaldi_synth #(
   parameter int CLK_DIV = 4,
   parameter int PHASE_W = 32,
   parameter int LUT_W   = 8
) (
   input logic             clk_i,
   input logic             rst_i,
   vivaldi_synth_if.slave  bus
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int W  = PHASE_W;
   logic [CW-1:0]       cnt;
   logic [W-1:0]        phase;
   logic                tick, v1, valid;
   logic signed [15:0]  raw, wave, sample, sine, sv, scaled;
   logic [6:0]          g, gc;
   logic [15:0]         s, f;
   logic [LUT_W-1:0]    idx;
   logic [LUT_W:0]      qi;
   logic signed [23:0]  prod;
   logic signed [15:0]  rom [0:2**LUT_W];
   // quarter-wave table, one extra entry so the peak value is exact
   for (genvar i = 0; i <= 2**LUT_W; i++) begin : g_rom
      assign rom[i] = 16'($rtoi(32767.0 * $sin(3.141592653589793 * real'(i) / real'(2 ** (LUT_W + 1))) + 0.5));
   end
   assign tick = bus.enable_i && cnt == CW'(CLK_DIV - 1);
   assign s    = phase[W-1 -: 16];
   assign f    = phase[W-2 -: 16];
   assign idx  = phase[W-3 -: LUT_W];
   assign qi   = phase[W-2] ? (LUT_W+1)'(2**LUT_W) - {1'b0, idx} : {1'b0, idx};
   assign sv   = rom[qi];
   assign sine = phase[W-1] ? -sv : sv;
   assign gc   = (bus.gain_pct_i > 7'd100) ? 7'd100 : bus.gain_pct_i;
   always_comb begin
      wave = bus.wave_sel_i == 2'd0 ? sine :
             bus.wave_sel_i == 2'd1 ? (phase[W-1] ? -16'sd32767 : 16'sd32767) :
             bus.wave_sel_i == 2'd2 ? s ^ 16'h8000 :
             (phase[W-1] ? ~f : f) ^ 16'h8000;
   end
   // signed division truncates toward zero, matching the required rounding
   assign prod   = 24'(raw) * 24'($signed({1'b0, g}));
   assign scaled = 16'(prod / 24'sd100);
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt    <= '0;
         phase  <= '0;
         v1     <= 1'b0;
         raw    <= '0;
         g      <= '0;
         sample <= '0;
         valid  <= 1'b0;
      end else begin
         if (bus.enable_i) cnt <= (cnt == CW'(CLK_DIV - 1)) ? '0 : cnt + 1'b1;
         v1 <= tick;
         if (tick) begin
            raw   <= wave;
            g     <= gc;
            phase <= phase + bus.phase_inc_i;
         end
         valid <= v1;
         if (v1) sample <= scaled;
      end
   end
   assign bus.sample_o       = sample;
   assign bus.sample_valid_o = valid;
endmodule

// File: tb/tb_vivaldi_synth.sv
// tb_vivaldi_synth: directed vectors for the vivaldi oscillator, CLK_DIV=4
module tb_vivaldi_synth;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vecs = 0;
   int   errs = 0;
   vivaldi_synth_if #(.PHASE_W(32)) bus ();
   vivaldi_synth #(.CLK_DIV(4), .PHASE_W(32), .LUT_W(8)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input int got, input int exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask
   // edges from call until a strobe is visible; samples on the falling edge
   task automatic wait_strobe(output int gap, output int smp);
      gap = 0;
      smp = 0;
      forever begin
         @(posedge clk);
         gap++;
         @(negedge clk);
         if (bus.sample_valid_o) begin
            smp = int'($signed(bus.sample_o));
            return;
         end
         if (gap > 64) begin
            vecs++;
            errs++;
            $display("FAIL strobe_timeout: got no strobe in %0d edges, expected one", gap);
            return;
         end
      end
   endtask
   task automatic start(input logic [1:0] sel, input logic [6:0] gain);
      @(negedge clk);
      rst = 1'b1;
      bus.enable_i    = 1'b1;
      bus.wave_sel_i  = sel;
      bus.gain_pct_i  = gain;
      bus.phase_inc_i = 32'h4000_0000;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask
   task automatic run(input string tag, input logic [1:0] sel, input logic [6:0] gain,
                      input int e0, input int e1, input int e2, input int e3);
      int gap, smp;
      int e [4];
      e = '{e0, e1, e2, e3};
      start(sel, gain);
      for (int k = 0; k < 8; k++) begin
         wait_strobe(gap, smp);
         chk($sformatf("%s_gap%0d", tag, k), gap, k == 0 ? 5 : 4);
         chk($sformatf("%s_smp%0d", tag, k), smp, e[k % 4]);
      end
   endtask
   initial begin
      int gap, smp, n, v;
      bus.enable_i    = 1'b1;
      bus.wave_sel_i  = 2'd3;
      bus.gain_pct_i  = 7'd77;
      bus.phase_inc_i = 32'h1234_5678;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("rst_valid%0d", k), int'(bus.sample_valid_o), 0);
         chk($sformatf("rst_sample%0d", k), int'($signed(bus.sample_o)), 0);
      end
      run("sine",   2'd0, 7'd100, 0, 32767, 0, -32767);
      run("square", 2'd1, 7'd100, 32767, 32767, -32767, -32767);
      run("saw",    2'd2, 7'd100, -32768, -16384, 0, 16384);
      run("tri",    2'd3, 7'd100, -32768, 0, 32767, -1);
      run("g50",    2'd0, 7'd50, 0, 16383, 0, -16383);
      run("g0",     2'd0, 7'd0, 0, 0, 0, 0);
      run("g127",   2'd0, 7'd127, 0, 32767, 0, -32767);
      run("saw_g50", 2'd2, 7'd50, -16384, -8192, 0, 8192);
      // enable dropped just after a tick: that sample must still drain
      start(2'd0, 7'd100);
      wait_strobe(gap, smp);
      wait_strobe(gap, smp);
      chk("en_pre", smp, 32767);
      repeat (3) @(negedge clk);
      bus.enable_i = 1'b0;
      n = 0;
      v = 99;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.sample_valid_o) begin
            n++;
            v = int'($signed(bus.sample_o));
         end
      end
      chk("en_drain_cnt", n, 1);
      chk("en_drain_smp", v, 0);
      bus.enable_i = 1'b1;
      wait_strobe(gap, smp);
      chk("en_resume_gap", gap, 5);
      chk("en_resume_smp", smp, -32767);
      wait_strobe(gap, smp);
      chk("en_next_gap", gap, 4);
      chk("en_next_smp", smp, 0);
      // reset pulse mid-run restarts phase and latency
      start(2'd0, 7'd100);
      wait_strobe(gap, smp);
      wait_strobe(gap, smp);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", int'(bus.sample_valid_o), 0);
      chk("mid_rst_sample", int'($signed(bus.sample_o)), 0);
      rst = 1'b0;
      wait_strobe(gap, smp);
      chk("mid_rst_gap", gap, 5);
      chk("mid_rst_smp0", smp, 0);
      wait_strobe(gap, smp);
      chk("mid_rst_smp1", smp, 32767);
      // waveform switched between ticks applies from the next tick
      start(2'd0, 7'd100);
      wait_strobe(gap, smp);
      chk("sel_first", smp, 0);
      bus.wave_sel_i = 2'd2;
      wait_strobe(gap, smp);
      chk("sel_gap", gap, 4);
      chk("sel_smp1", smp, -16384);
      wait_strobe(gap, smp);
      chk("sel_smp2", smp, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/vivaldi_synth.md
Name: vivaldi_synth

Overview:
Single-voice digital audio oscillator and the synthesizable core behind the vivaldi simulation runner. A phase accumulator advances once per sample tick from an internal clock divider, and the phase is mapped to one of four waveforms: sine, square, sawtooth or triangle. The raw sample is scaled by a 0–100 % gain and emitted as a signed 16-bit sample with a one-cycle valid strobe, which the runner collects into a WAV file.

Parameters:
CLK_DIV, 4, clock cycles per output sample (≥3); e.g. 2083 for 48 kHz at 100 MHz.
PHASE_W, 32, phase accumulator width (≥18).
LUT_W, 8, log2 of the quarter-wave sine ROM resolution.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
enable_i  in  1  run the sample-rate divider; low freezes the divider and phase
wave_sel_i  in  2  0=sine, 1=square, 2=sawtooth, 3=triangle
gain_pct_i  in  7  output gain in percent; values >100 are clamped to 100
phase_inc_i  in  PHASE_W  phase increment per sample (sets pitch)
sample_o  out  16  signed output sample
sample_valid_o  out  1  one-cycle strobe: sample_o holds a new sample

Behaviour:
- Reset: divider count=0, phase=0, pipeline valids=0, sample_o=0, sample_valid_o=0.
- Divider: cnt increments each cycle while enable_i=1 and wraps CLK_DIV-1→0. tick = enable_i && cnt==CLK_DIV-1. With enable_i low, cnt holds and no tick occurs.
- Tick cycle (stage 1 register):
  - raw <= wave(phase, wave_sel_i)
  - g <= min(gain_pct_i,100)
  - v1 <= 1
  - phase <= phase+phase_inc_i, modulo 2^PHASE_W
  - The first sample therefore uses phase 0.
- Stage 2: when v1=1, sample_o <= scale(raw,g) and sample_valid_o <= 1; otherwise sample_valid_o <= 0 and sample_o holds its value.
- Latency: after reset release with enable_i high, the first tick is the CLK_DIV-th cycle and sample_valid_o is high in cycle CLK_DIV+2. Strobes then repeat every CLK_DIV cycles.
- Sampling of inputs: wave_sel_i, gain_pct_i and phase_inc_i are sampled only at ticks; changes between ticks take effect at the next tick. Deasserting enable_i lets samples already in flight drain normally.
- Waveforms (p = phase, MSB p[W-1]; s = p[W-1:W-16]):
  - square: +32767 if MSB=0, else −32767.
  - sawtooth: s − 32768, i.e. MSB inverted.
  - triangle: f = MSB ? ~p[W-2:W-17] : p[W-2:W-17]; result = f − 32768.
  - sine:
    - ROM[i] = round(32767·sin(π/2·i/2^LUT_W)) for i = 0..2^LUT_W, so the ROM has 2^LUT_W+1 entries.
    - idx = p[W-3:W-2-LUT_W].
    - Quarter bit p[W-2]=1 → use ROM[2^LUT_W − idx], else ROM[idx].
    - MSB=1 → negate.
- Gain: scale = trunc_toward_zero(raw·g/100), bit-exact. Any reciprocal-multiply implementation must match this exactly. Result range is −32767..32767 except saw/tri at −32768 with g=100.
- Reset mid-operation: all state returns to reset values next edge, and in-flight samples are discarded.

Test Plan:
- Reset with rst_i=1 for 3 cycles, inputs arbitrary → sample_o=0, sample_valid_o=0 throughout.
- CLK_DIV=4, gain 100, phase_inc=2^30, sine, enable from reset release:
  - first strobe in cycle 6;
  - successive strobes every 4 cycles;
  - samples 0, 32767, 0, −32767, repeating.
- Same stimulus for each remaining waveform:
  - square → 32767, 32767, −32767, −32767;
  - sawtooth → −32768, −16384, 0, 16384;
  - triangle → −32768, 0, 32767, −1.
- Gain on sine, phase_inc=2^30:
  - gain 50 → 0, 16383, 0, −16383;
  - gain 0 → all 0;
  - gain 127 → identical to gain 100.
- Enable control: drop enable_i for 20 cycles mid-stream → no strobes after the in-flight sample drains. Re-enable → sequence resumes at the next phase with no skipped or repeated sample.
- Mid-run changes:
  - rst_i pulsed mid-run → next strobe is again at cycle CLK_DIV+2 after release, with phase restarting at 0;
  - wave_sel_i changed between ticks → applies starting with the next tick's sample.
